// File: rtl/mem_rsp_tracker_pkg.sv
// Shared types for the data-SRAM response tracker.
//   mem_size_e  : access size encoding carried from EXE (byte/half/word/dword)
//   size_bits   : access size in bits
//   entry_width : packed width of one tracker entry, for cross-block sizing
package mem_rsp_tracker_pkg;

  typedef enum logic [1:0] {
    MemSzB = 2'd0,
    MemSzH = 2'd1,
    MemSzW = 2'd2,
    MemSzD = 2'd3
  } mem_size_e;

  function automatic int unsigned size_bits(mem_size_e sz);
    return 32'd8 << sz;
  endfunction

  // {wr, size, sign, ofs, rd, cancel, done, data}
  function automatic int unsigned entry_width(int unsigned data_w, int unsigned rd_w);
    return 1 + 2 + 1 + $clog2(data_w / 8) + rd_w + 1 + 1 + data_w;
  endfunction

endpackage

// File: rtl/mem_rsp_tracker_if.sv
// Bundle between the EXE request port, the data-SRAM response side and WB.
//   master : drives flush, request fields, data_ok/rdata and rsp_ready
//   slave  : the tracker; returns can_issue, outstanding, rsp_* and proto_err
interface mem_rsp_tracker_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned RD_W   = 5
);
  localparam int unsigned OfsW = $clog2(DATA_W / 8);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              flush;
  logic              req_fire;
  logic              req_wr;
  logic [1:0]        req_size;
  logic              req_sign;
  logic [OfsW-1:0]   req_ofs;
  logic [RD_W-1:0]   req_rd;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;
  logic              can_issue;
  logic [CntW-1:0]   outstanding;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_wr;
  logic [RD_W-1:0]   rsp_rd;
  logic [DATA_W-1:0] rsp_data;
  logic              proto_err;

  modport master (
    output flush, req_fire, req_wr, req_size, req_sign, req_ofs, req_rd,
    output data_ok, rdata, rsp_ready,
    input  can_issue, outstanding, rsp_valid, rsp_wr, rsp_rd, rsp_data, proto_err
  );

  modport slave (
    input  flush, req_fire, req_wr, req_size, req_sign, req_ofs, req_rd,
    input  data_ok, rdata, rsp_ready,
    output can_issue, outstanding, rsp_valid, rsp_wr, rsp_rd, rsp_data, proto_err
  );

endinterface

// File: rtl/load_align_ext.sv
// Combinational load-lane extraction and sign/zero extension.
//   data   : raw bus word
//   size   : access size
//   sign   : sign-extend when set
//   ofs    : byte offset of the access within the bus word
//   result : selected lane, extended to DATA_W
module load_align_ext
  import mem_rsp_tracker_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OFS_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data,
  input  mem_size_e         size,
  input  logic              sign,
  input  logic [OFS_W-1:0]  ofs,
  output logic [DATA_W-1:0] result
);

  logic [OFS_W-1:0]  lane_ofs;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] left;
  int unsigned       bits;
  int unsigned       pad;

  always_comb begin
    lane_ofs = '0;
    unique case (size)
      MemSzB:  lane_ofs = ofs;
      MemSzH:  lane_ofs = ofs & ~OFS_W'(1);
      MemSzW:  lane_ofs = ofs & ~OFS_W'(3);
      default: lane_ofs = '0;
    endcase
    bits    = size_bits(size);
    pad     = (bits >= DATA_W) ? 0 : DATA_W - bits;
    shifted = data >> {lane_ofs, 3'b000};
    // Park the lane at the MSB end, then shift back so >>> supplies the extension.
    left    = shifted << pad;
    result  = sign ? $unsigned($signed(left) >>> pad) : (left >> pad);
  end

endmodule

// File: rtl/mem_rsp_tracker.sv
// In-order tracker of outstanding data-SRAM requests between EXE and MEM/WB.
//   clk, resetn : clock and synchronous active-low reset
//   bus         : request fields from EXE, data_ok/rdata from the SRAM, flush from MEM,
//                 can_issue/outstanding back to EXE, rsp_* handshake to WB, sticky proto_err
// Entries live in a circular buffer addressed by head (retire), ret (next to receive)
// and tail (allocate), each with a wrap bit. Returned data is held until WB takes it.
module mem_rsp_tracker
  import mem_rsp_tracker_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned RD_W   = 5
) (
  input logic              clk,
  input logic              resetn,
  mem_rsp_tracker_if.slave bus
);

  localparam int unsigned OfsW = $clog2(DATA_W / 8);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW:0] ptr_t;

  ptr_t head_q, head_d;
  ptr_t ret_q, ret_d;
  ptr_t tail_q, tail_d;
  logic [DEPTH-1:0] cancel_q, cancel_d;
  logic proto_err_q, proto_err_d;

  // Payload; validity comes from the pointers, so no reset is needed here.
  logic [DEPTH-1:0]  wr_q;
  logic [DEPTH-1:0]  sign_q;
  mem_size_e         size_q [DEPTH];
  logic [OfsW-1:0]   ofs_q  [DEPTH];
  logic [RD_W-1:0]   rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PtrW-1:0] head_idx, ret_idx, tail_idx;
  logic [CntW-1:0] count;
  logic            full, awaiting, returned, head_cancel;
  logic            alloc, ret_ev, rsp_valid, retire, auto_retire;
  logic [DATA_W-1:0] aligned;

  assign head_idx = head_q[PtrW-1:0];
  assign ret_idx  = ret_q[PtrW-1:0];
  assign tail_idx = tail_q[PtrW-1:0];

  assign count       = tail_q - head_q;
  assign full        = (count == CntW'(DEPTH));
  assign awaiting    = (ret_q != tail_q);
  assign returned    = (head_q != ret_q);
  assign head_cancel = cancel_q[head_idx];

  assign alloc       = bus.req_fire & ~full;
  assign ret_ev      = bus.data_ok & awaiting;
  assign rsp_valid   = returned & ~head_cancel & ~bus.flush;
  assign retire      = rsp_valid & bus.rsp_ready;
  // A cancelled entry whose data is back drains itself without bothering WB.
  assign auto_retire = returned & head_cancel;

  always_comb begin
    head_d      = head_q;
    ret_d       = ret_q + ptr_t'(ret_ev);
    tail_d      = tail_q + ptr_t'(alloc);
    cancel_d    = cancel_q;
    proto_err_d = proto_err_q | (bus.data_ok & ~awaiting) | (bus.req_fire & full);

    if (bus.flush) begin
      head_d = ret_q;
      // Everything already sent to memory but not yet answered is now dead.
      for (int i = 0; i < DEPTH; i++) begin
        if ({1'b0, PtrW'(i) - ret_idx} < (tail_q - ret_q)) begin
          cancel_d[i] = 1'b1;
        end
      end
    end else if (retire || auto_retire) begin
      head_d = head_q + ptr_t'(1);
    end

    // A request leaving in the flush cycle belongs to the killed stream too.
    if (alloc) begin
      cancel_d[tail_idx] = bus.flush;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q      <= '0;
      ret_q       <= '0;
      tail_q      <= '0;
      cancel_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      ret_q       <= ret_d;
      tail_q      <= tail_d;
      cancel_q    <= cancel_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      wr_q[tail_idx]   <= bus.req_wr;
      sign_q[tail_idx] <= bus.req_sign;
      size_q[tail_idx] <= mem_size_e'(bus.req_size);
      ofs_q[tail_idx]  <= bus.req_ofs;
      rd_q[tail_idx]   <= bus.req_rd;
    end
    if (ret_ev) begin
      data_q[ret_idx] <= bus.rdata;
    end
  end

  load_align_ext #(
    .DATA_W (DATA_W),
    .OFS_W  (OfsW)
  ) u_align (
    .data   (data_q[head_idx]),
    .size   (size_q[head_idx]),
    .sign   (sign_q[head_idx]),
    .ofs    (ofs_q[head_idx]),
    .result (aligned)
  );

  assign bus.can_issue   = ~full;
  assign bus.outstanding = count;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_wr      = wr_q[head_idx];
  assign bus.rsp_rd      = rd_q[head_idx];
  assign bus.rsp_data    = wr_q[head_idx] ? '0 : aligned;
  assign bus.proto_err   = proto_err_q;

endmodule

// File: tb/tb_mem_rsp_tracker.sv
module tb_mem_rsp_tracker;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_rsp_tracker_if #(.DATA_W(32), .DEPTH(2), .RD_W(5)) bus ();
  mem_rsp_tracker_if #(.DATA_W(64), .DEPTH(2), .RD_W(5)) bus64 ();

  mem_rsp_tracker #(.DATA_W(32), .DEPTH(2), .RD_W(5)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  mem_rsp_tracker #(.DATA_W(64), .DEPTH(2), .RD_W(5)) dut64 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus64)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard for the 32-bit instance.
  typedef struct {
    logic       wr;
    logic [1:0] size;
    logic       sign;
    logic [1:0] ofs;
    logic [4:0] rd;
    logic       cancel;
  } pend_t;

  typedef struct {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] data;
  } rsp_t;

  pend_t pend_q[$];
  rsp_t  exp_q[$];
  logic  m_proto = 1'b0;

  function automatic logic [31:0] ref_load(logic [31:0] raw, logic [1:0] size, logic sign,
                                           logic [1:0] ofs);
    logic [7:0]  b;
    logic [15:0] h;
    case (size)
      2'd0: begin
        b = raw[{ofs, 3'b000} +: 8];
        return sign ? {{24{b[7]}}, b} : {24'h0, b};
      end
      2'd1: begin
        h = raw[{ofs[1], 4'b0000} +: 16];
        return sign ? {{16{h[15]}}, h} : {16'h0, h};
      end
      default: return raw;
    endcase
  endfunction

  task automatic model_step();
    pend_t p;
    rsp_t  r;
    logic  exp_valid;
    exp_valid = (exp_q.size() != 0) && !bus.flush;
    check_eq("rsp_valid", bus.rsp_valid, exp_valid);
    if (exp_valid) begin
      check_eq("rsp_wr", bus.rsp_wr, exp_q[0].wr);
      check_eq("rsp_rd", bus.rsp_rd, exp_q[0].rd);
      check_eq("rsp_data", bus.rsp_data, exp_q[0].data);
    end
    check_eq("proto_err", bus.proto_err, m_proto);
    if (exp_valid && bus.rsp_ready) void'(exp_q.pop_front());
    if (bus.flush) begin
      exp_q.delete();
      foreach (pend_q[i]) pend_q[i].cancel = 1'b1;
    end
    if (bus.data_ok) begin
      if (pend_q.size() == 0) begin
        m_proto = 1'b1;
      end else begin
        p = pend_q.pop_front();
        if (!p.cancel) begin
          r.wr   = p.wr;
          r.rd   = p.rd;
          r.data = p.wr ? 32'h0 : ref_load(bus.rdata, p.size, p.sign, p.ofs);
          exp_q.push_back(r);
        end
      end
    end
    if (bus.req_fire) begin
      p.wr = bus.req_wr; p.size = bus.req_size; p.sign = bus.req_sign;
      p.ofs = bus.req_ofs; p.rd = bus.req_rd; p.cancel = bus.flush;
      pend_q.push_back(p);
    end
  endtask

  // One clock: check/model at the falling edge, then release pulse inputs after the rise.
  task automatic tick();
    @(negedge clk);
    if (resetn) begin
      model_step();
    end else begin
      pend_q.delete();
      exp_q.delete();
      m_proto = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.req_fire = 1'b0; bus.data_ok = 1'b0; bus.flush = 1'b0;
    bus64.req_fire = 1'b0; bus64.data_ok = 1'b0; bus64.flush = 1'b0;
    #1;
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!bus.can_issue && n < 20) begin
      tick();
      n++;
    end
    check_eq("can_issue_wait", bus.can_issue, 1'b1);
  endtask

  task automatic issue(input logic wr, input logic [1:0] size, input logic sign,
                       input logic [1:0] ofs, input logic [4:0] rd);
    bus.req_fire = 1'b1; bus.req_wr = wr; bus.req_size = size;
    bus.req_sign = sign; bus.req_ofs = ofs; bus.req_rd = rd;
    tick();
  endtask

  task automatic resp(input logic [31:0] data);
    bus.data_ok = 1'b1;
    bus.rdata   = data;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush = 0; bus.req_fire = 0; bus.req_wr = 0; bus.req_size = 0; bus.req_sign = 0;
    bus.req_ofs = 0; bus.req_rd = 0; bus.data_ok = 0; bus.rdata = 0; bus.rsp_ready = 1;
    bus64.flush = 0; bus64.req_fire = 0; bus64.req_wr = 0; bus64.req_size = 0;
    bus64.req_sign = 0; bus64.req_ofs = 0; bus64.req_rd = 0; bus64.data_ok = 0;
    bus64.rdata = 0; bus64.rsp_ready = 1;

    tick();
    tick();
    resetn = 1'b1;
    check_eq("rst_can_issue", bus.can_issue, 1'b1);
    check_eq("rst_outstanding", bus.outstanding, 0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check_eq("rst_proto_err", bus.proto_err, 1'b0);
    check_eq("rst64_rsp_valid", bus64.rsp_valid, 1'b0);

    // Single signed byte load from lane 3.
    issue(1'b0, 2'd0, 1'b1, 2'd3, 5'd7);
    resp(32'h8012_3456);
    check_eq("t1_valid", bus.rsp_valid, 1'b1);
    check_eq("t1_rd", bus.rsp_rd, 5'd7);
    check_eq("t1_data", bus.rsp_data, 32'hFFFF_FF80);
    tick();

    // Back-to-back loads fill the buffer.
    issue(1'b0, 2'd2, 1'b0, 2'd0, 5'd1);
    issue(1'b0, 2'd1, 1'b0, 2'd2, 5'd2);
    check_eq("t2_can_issue", bus.can_issue, 1'b0);
    check_eq("t2_outstanding", bus.outstanding, 2);
    resp(32'hAABB_CCDD);
    resp(32'h8765_4321);
    check_eq("t2_data_hi_half", bus.rsp_data, 32'h0000_8765);
    tick();
    check_eq("t2_drained", bus.outstanding, 0);

    // WB back-pressure: store plus signed half load both buffered.
    bus.rsp_ready = 1'b0;
    issue(1'b1, 2'd2, 1'b0, 2'd0, 5'd3);
    issue(1'b0, 2'd1, 1'b1, 2'd0, 5'd4);
    resp(32'hFFFF_FFFF);
    resp(32'h1234_9ABC);
    tick();
    tick();
    check_eq("t3_outstanding", bus.outstanding, 2);
    check_eq("t3_head_store", bus.rsp_wr, 1'b1);
    bus.rsp_ready = 1'b1;
    tick();
    check_eq("t3_second_data", bus.rsp_data, 32'hFFFF_9ABC);
    tick();
    check_eq("t3_drained", bus.outstanding, 0);

    // Flush with two requests in flight; their responses must vanish.
    issue(1'b0, 2'd2, 1'b0, 2'd0, 5'd5);
    issue(1'b0, 2'd2, 1'b0, 2'd0, 5'd6);
    bus.flush = 1'b1;
    tick();
    check_eq("t4_full_after_flush", bus.can_issue, 1'b0);
    resp(32'h1111_1111);
    wait_issue();
    issue(1'b0, 2'd2, 1'b0, 2'd0, 5'd9);
    resp(32'h2222_2222);
    check_eq("t4_no_stale", bus.rsp_valid, 1'b0);
    resp(32'h1234_5678);
    check_eq("t4_new_rd", bus.rsp_rd, 5'd9);
    check_eq("t4_new_data", bus.rsp_data, 32'h1234_5678);
    tick();
    check_eq("t4_drained", bus.outstanding, 0);

    // Request leaving in the flush cycle is cancelled.
    bus.flush = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 2'd0, 5'd10);
    check_eq("t5_outstanding", bus.outstanding, 1);
    resp(32'hFFFF_0000);
    check_eq("t5_dropped", bus.rsp_valid, 1'b0);
    tick();
    check_eq("t5_drained", bus.outstanding, 0);

    // Flush discards data already returned but not yet taken by WB.
    bus.rsp_ready = 1'b0;
    issue(1'b0, 2'd0, 1'b0, 2'd1, 5'd12);
    resp(32'h0000_5500);
    check_eq("t7_held", bus.rsp_valid, 1'b1);
    bus.flush = 1'b1;
    tick();
    check_eq("t7_discarded", bus.outstanding, 0);
    bus.rsp_ready = 1'b1;

    // Spurious response with nothing awaiting.
    resp(32'hDEAD_BEEF);
    check_eq("t6_proto_err", bus.proto_err, 1'b1);
    check_eq("t6_no_valid", bus.rsp_valid, 1'b0);
    tick();
    tick();
    check_eq("t6_sticky", bus.proto_err, 1'b1);

    // 64-bit instance: unsigned word from upper lane, signed byte, dword.
    bus64.data_ok = 1'b1;
    tick();
    check_eq("w64_proto_err", bus64.proto_err, 1'b1);
    bus64.req_fire = 1'b1; bus64.req_size = 2'd2; bus64.req_sign = 1'b0;
    bus64.req_ofs = 3'd4; bus64.req_rd = 5'd11; bus64.req_wr = 1'b0;
    tick();
    bus64.data_ok = 1'b1; bus64.rdata = 64'hDEAD_BEEF_0000_0001;
    tick();
    check_eq("w64_valid", bus64.rsp_valid, 1'b1);
    check_eq("w64_rd", bus64.rsp_rd, 5'd11);
    check_eq("w64_word", bus64.rsp_data, 64'h0000_0000_DEAD_BEEF);
    bus64.req_fire = 1'b1; bus64.req_size = 2'd0; bus64.req_sign = 1'b1;
    bus64.req_ofs = 3'd7; bus64.req_rd = 5'd13;
    tick();
    bus64.data_ok = 1'b1; bus64.rdata = 64'h8000_0000_0000_0001;
    tick();
    check_eq("w64_byte", bus64.rsp_data, 64'hFFFF_FFFF_FFFF_FF80);
    bus64.req_fire = 1'b1; bus64.req_size = 2'd3; bus64.req_sign = 1'b0;
    bus64.req_ofs = 3'd0; bus64.req_rd = 5'd14;
    tick();
    bus64.data_ok = 1'b1; bus64.rdata = 64'h8000_0000_0000_0001;
    tick();
    check_eq("w64_dword", bus64.rsp_data, 64'h8000_0000_0000_0001);
    tick();
    check_eq("w64_drained", bus64.outstanding, 0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
